// File: rtl/dmem_pipe.sv
// -----------------------------------------------------------------------------
// dmem_pipe
//   Word-organised data RAM with byte-lane write enables and an RD_LAT-deep
//   response pipeline. Accepts one request per clock without back-pressure;
//   every request (read or write, in or out of range) produces exactly one
//   response strobe RD_LAT cycles later, in issue order. Two saturating
//   counters track accepted in-range reads and writes.
//
// Parameters
//   DW      data width in bits (multiple of 8)
//   AW      byte-address width
//   DEPTH   number of DW-bit words (power of two, >= 2)
//   RD_LAT  request-to-response latency in cycles (1..4)
//   CW      access counter width
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   req       request valid, sampled every cycle
//   daddr     byte address
//   dwdata    write data
//   we        byte-lane write enables; all-zero means read
//   drdata    response data (holds its last value between responses)
//   rvalid    response strobe
//   err       out-of-range flag, only ever high together with rvalid
//   rd_count  accepted in-range reads (saturating)
//   wr_count  accepted in-range writes (saturating)
// -----------------------------------------------------------------------------
module dmem_pipe #(
   parameter int unsigned DW     = 32,
   parameter int unsigned AW     = 32,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned CW     = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic [AW-1:0]   daddr,
   input  logic [DW-1:0]   dwdata,
   input  logic [DW/8-1:0] we,
   output logic [DW-1:0]   drdata,
   output logic            rvalid,
   output logic            err,
   output logic [CW-1:0]   rd_count,
   output logic [CW-1:0]   wr_count
);

   localparam int unsigned NB   = DW / 8;
   localparam int unsigned OFFW = $clog2(NB);
   localparam int unsigned IDXW = $clog2(DEPTH);
   localparam int unsigned HIW  = OFFW + IDXW;

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic [IDXW-1:0] w_idx;
   logic            w_in_range;

   assign w_idx = daddr[OFFW +: IDXW];

   // Range check looks at every address bit above the word index so that
   // large addresses can never alias back into the array.
   generate
      if (AW > HIW) begin : g_hi_bits
         assign w_in_range = ~|daddr[AW-1:HIW];
      end else begin : g_no_hi_bits
         assign w_in_range = 1'b1;
      end

      // Byte-offset bits select nothing: misaligned addresses alias to the
      // containing word.
      if (OFFW > 0) begin : g_offs
         logic w_unused_offs;
         assign w_unused_offs = ^daddr[OFFW-1:0];
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Request classification
   // ---------------------------------------------------------------------------
   logic w_is_wr;
   logic w_acc;
   logic w_rd_acc;
   logic w_wr_acc;

   assign w_is_wr  = |we;
   assign w_acc    = req & w_in_range;
   assign w_rd_acc = w_acc & ~w_is_wr;
   assign w_wr_acc = w_acc & w_is_wr;

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] w_old;
   logic [DW-1:0] w_merged;
   logic [DW-1:0] w_resp_data;

   assign w_old = r_mem[w_idx];

   // Lane merge of the current word with the enabled write lanes; this is
   // both the value committed and the write-first response data.
   always_comb begin
      w_merged = w_old;
      for (int i = 0; i < int'(NB); i++) begin
         if (we[i]) begin
            w_merged[8*i +: 8] = dwdata[8*i +: 8];
         end
      end
   end

   // Reads see the array combinationally, so a write committed at the previous
   // edge is already visible; no bypass path is required.
   always_comb begin
      w_resp_data = '0;
      if (w_in_range) begin
         w_resp_data = w_is_wr ? w_merged : w_old;
      end
   end

   // Contents survive reset; reset only blocks the write so a request that
   // coincides with reset is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // array intentionally left untouched
      end else if (w_wr_acc) begin
         r_mem[w_idx] <= w_merged;
      end
   end

   // ---------------------------------------------------------------------------
   // Response pipeline: RD_LAT stages of {valid, err, data}
   // ---------------------------------------------------------------------------
   logic [RD_LAT-1:0] r_vld;
   logic [RD_LAT-1:0] r_err;
   logic [DW-1:0]     r_dat [RD_LAT];

   // Data stages only load when a valid entry moves in, so the output stage
   // keeps the last response data through idle cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld <= '0;
         r_err <= '0;
         for (int k = 0; k < int'(RD_LAT); k++) begin
            r_dat[k] <= '0;
         end
      end else begin
         r_vld[0] <= req;
         r_err[0] <= req & ~w_in_range;
         if (req) begin
            r_dat[0] <= w_resp_data;
         end
         for (int k = 1; k < int'(RD_LAT); k++) begin
            r_vld[k] <= r_vld[k-1];
            r_err[k] <= r_err[k-1];
            if (r_vld[k-1]) begin
               r_dat[k] <= r_dat[k-1];
            end
         end
      end
   end

   assign rvalid = r_vld[RD_LAT-1];
   assign err    = r_err[RD_LAT-1];
   assign drdata = r_dat[RD_LAT-1];

   // ---------------------------------------------------------------------------
   // Saturating access counters, updated at the request edge
   // ---------------------------------------------------------------------------
   logic [CW-1:0] r_rd_count;
   logic [CW-1:0] r_wr_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         if (w_rd_acc && (r_rd_count != '1)) begin
            r_rd_count <= r_rd_count + CW'(1);
         end
         if (w_wr_acc && (r_wr_count != '1)) begin
            r_wr_count <= r_wr_count + CW'(1);
         end
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;

endmodule

// File: tb/tb_dmem_pipe.sv
// -----------------------------------------------------------------------------
// tb_dmem_pipe
//   Three instances share one request bus: RD_LAT=1/CW=4, RD_LAT=3 and
//   RD_LAT=4, each with its own reset. A vector table drives the RD_LAT=1
//   instance; hand-written sequences cover pipelined reads, reset mid-flight
//   and counter saturation.
// -----------------------------------------------------------------------------
module tb_dmem_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst3, rst4;
   logic        req;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  we;

   logic [31:0] drdata1, drdata3, drdata4;
   logic        rvalid1, rvalid3, rvalid4;
   logic        err1, err3, err4;
   logic [3:0]  rd_count1, wr_count1;
   logic [15:0] rd_count3, wr_count3, rd_count4, wr_count4;

   dmem_pipe #(.DW(32), .AW(32), .DEPTH(1024), .RD_LAT(1), .CW(4)) u_dut1 (
      .clk(clk), .rst(rst1), .req(req), .daddr(daddr), .dwdata(dwdata), .we(we),
      .drdata(drdata1), .rvalid(rvalid1), .err(err1),
      .rd_count(rd_count1), .wr_count(wr_count1)
   );

   dmem_pipe #(.DW(32), .AW(32), .DEPTH(1024), .RD_LAT(3), .CW(16)) u_dut3 (
      .clk(clk), .rst(rst3), .req(req), .daddr(daddr), .dwdata(dwdata), .we(we),
      .drdata(drdata3), .rvalid(rvalid3), .err(err3),
      .rd_count(rd_count3), .wr_count(wr_count3)
   );

   dmem_pipe #(.DW(32), .AW(32), .DEPTH(1024), .RD_LAT(4), .CW(16)) u_dut4 (
      .clk(clk), .rst(rst4), .req(req), .daddr(daddr), .dwdata(dwdata), .we(we),
      .drdata(drdata4), .rvalid(rvalid4), .err(err4),
      .rd_count(rd_count4), .wr_count(wr_count4)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w);
      req    = r;
      daddr  = a;
      dwdata = d;
      we     = w;
   endtask

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  we;
      logic        exp_vld;
      logic        exp_err;
      logic [31:0] exp_data;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   initial begin
      // Responses of the RD_LAT=1 instance, sampled one cycle after each vector
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 1};
      vecs[1]  = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1, 1};
      vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 32'h1122_3344, 1, 2};
      vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1'b1, 1'b0, 32'h11BB_33DD, 1, 3};
      vecs[4]  = '{1'b1, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 1'b0, 32'h11BB_33DD, 2, 3};
      vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b0, 1'b0, 32'h11BB_33DD, 2, 3};
      vecs[6]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 4'hF, 1'b1, 1'b0, 32'h0000_0001, 2, 4};
      vecs[7]  = '{1'b1, 32'h0000_0004, 32'h0000_0002, 4'hF, 1'b1, 1'b0, 32'h0000_0002, 2, 5};
      vecs[8]  = '{1'b1, 32'h0000_0008, 32'h0000_0003, 4'hF, 1'b1, 1'b0, 32'h0000_0003, 2, 6};
      vecs[9]  = '{1'b1, 32'h0000_1000, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0,         2, 6};
      vecs[10] = '{1'b1, 32'h0000_1000, 32'h0000_0005, 4'hF, 1'b1, 1'b1, 32'h0,         2, 6};
      vecs[11] = '{1'b1, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0000_0001, 3, 6};
      vecs[12] = '{1'b1, 32'h0000_0023, 32'h0,         4'h0, 1'b1, 1'b0, 32'h11BB_33DD, 4, 6};
      vecs[13] = '{1'b1, 32'hFFFF_FFF0, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0,         4, 6};
      vecs[14] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 1'b0, 32'h0,         4, 6};

      rst1 = 1'b0;
      rst3 = 1'b0;
      rst4 = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 4'h0);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("reset rvalid", 32'(rvalid1), 32'h0);
      chk("reset err", 32'(err1), 32'h0);
      chk("reset drdata", drdata1, 32'h0);
      chk("reset rd_count", 32'(rd_count1), 32'h0);
      chk("reset wr_count", 32'(wr_count1), 32'h0);

      // Release; vector 0 must be accepted at the very first edge with rst=1
      rst1 = 1'b1;
      rst3 = 1'b1;
      rst4 = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].req, vecs[i].addr, vecs[i].wdata, vecs[i].we);
         @(negedge clk);
         chk($sformatf("v%0d rvalid", i), 32'(rvalid1), 32'(vecs[i].exp_vld));
         chk($sformatf("v%0d err", i), 32'(err1), 32'(vecs[i].exp_err));
         chk($sformatf("v%0d drdata", i), drdata1, vecs[i].exp_data);
         chk($sformatf("v%0d rd_count", i), 32'(rd_count1), vecs[i].exp_rd);
         chk($sformatf("v%0d wr_count", i), 32'(wr_count1), vecs[i].exp_wr);
      end

      repeat (4) @(negedge clk);

      // RD_LAT=3: back-to-back reads of 0x0, 0x4, 0x8 holding 1, 2, 3
      for (int c = 0; c < 7; c++) begin
         if (c < 3) drive(1'b1, 32'(4 * c), 32'h0, 4'h0);
         else       drive(1'b0, 32'h0, 32'h0, 4'h0);
         @(negedge clk);
         chk($sformatf("lat3 c%0d rvalid", c), 32'(rvalid3), (c >= 2 && c <= 4) ? 32'h1 : 32'h0);
         chk($sformatf("lat3 c%0d err", c), 32'(err3), 32'h0);
         if (c >= 2 && c <= 4) chk($sformatf("lat3 c%0d drdata", c), drdata3, 32'(c - 1));
      end

      repeat (4) @(negedge clk);

      // RD_LAT=4: two reads in flight, then reset with a colliding request
      drive(1'b1, 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      drive(1'b1, 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      drive(1'b1, 32'h10, 32'h0, 4'h0);
      rst4 = 1'b0;
      #1;
      chk("async rst rvalid", 32'(rvalid4), 32'h0);
      chk("async rst err", 32'(err4), 32'h0);
      chk("async rst drdata", drdata4, 32'h0);
      chk("async rst rd_count", 32'(rd_count4), 32'h0);
      @(negedge clk);
      rst4 = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         chk($sformatf("flush c%0d rvalid", j), 32'(rvalid4), 32'h0);
      end
      chk("flush rd_count", 32'(rd_count4), 32'h0);
      chk("flush wr_count", 32'(wr_count4), 32'h0);

      // RAM contents survived the reset
      drive(1'b1, 32'h10, 32'h0, 4'h0);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         drive(1'b0, 32'h0, 32'h0, 4'h0);
         chk($sformatf("post rst c%0d rvalid", j), 32'(rvalid4), (j == 4) ? 32'h1 : 32'h0);
      end
      chk("post rst drdata", drdata4, 32'hDEAD_BEEF);
      chk("post rst rd_count", 32'(rd_count4), 32'h1);

      // CW=4 saturation: 20 reads, count stops at 15
      rst1 = 1'b0;
      @(negedge clk);
      rst1 = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         drive(1'b1, 32'h0, 32'h0, 4'h0);
         @(negedge clk);
         chk($sformatf("sat n%0d rd_count", n), 32'(rd_count1), (n < 15) ? 32'(n) : 32'd15);
      end
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      chk("sat wr_count", 32'(wr_count1), 32'h0);
      chk("sat drdata", drdata1, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
- Parametrised successor to the single-cycle data memory that sits on the CPU daddr/dwdata/drdata/we bus.
- Word-organised RAM with byte-lane write enables and a configurable read pipeline of RD_LAT cycles.
- Accepts one request per clock and produces a response strobe carrying data and error status.
- Provides saturating read and write access counters so testbenches can check memory traffic without probing the CPU.

Parameters:
- DW, 32, data width in bits; multiple of 8, range 8..128.
- AW, 32, byte-address width.
- DEPTH, 1024, number of DW-bit words; power of two.
- RD_LAT, 1, request-to-response latency in cycles, range 1..4.
- CW, 16, width of each access counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  request valid; sampled every cycle, no back-pressure.
- daddr  in  AW  byte address.
- dwdata  in  DW  write data.
- we  in  DW/8  byte-lane write enables; all-zero means read.
- drdata  out  DW  response data.
- rvalid  out  1  response strobe.
- err  out  1  out-of-range flag, valid only with rvalid.
- rd_count  out  CW  accepted in-range reads.
- wr_count  out  CW  accepted in-range writes.

Behaviour:
- Word index: idx = daddr >> log2(DW/8). Low byte-offset bits are ignored; misaligned addresses alias to the containing word.
- In range: idx < DEPTH. An out-of-range request writes nothing, does not count, and its response has err=1 and drdata=0.
- Write (req=1, we!=0, in range):
  - At the edge of cycle T, byte lane i is updated with dwdata[8i+7:8i] iff we[i]=1.
  - Lanes with we[i]=0 keep their old value.
- Response timing: every accepted request, read or write, yields exactly one response with rvalid=1 at cycle T+RD_LAT. Requests issued back-to-back give back-to-back responses in issue order.
- Response data:
  - Read: the word contents as they stand after all writes committed up to and including the edge of cycle T.
  - Write: the merged post-write word (write-first).
- Hazards:
  - A read in cycle T+1 of a word written in cycle T returns the new data.
  - No bypass is needed beyond that, because writes commit at request time.
- Pipeline: RD_LAT-deep shift register of {valid, err, data}. With RD_LAT=1 this is a single register stage after the RAM read.
- Counters:
  - rd_count increments on each accepted in-range read; wr_count on each accepted in-range write.
  - Both saturate at 2^CW-1 and do not wrap.
  - Each increments at the request edge, not the response edge.
- Idle: when req=0, rvalid=0 RD_LAT cycles later. drdata holds its last value; err=0 when rvalid=0.
- Reset (rst=0, asynchronous, any time):
  - rvalid=0, err=0, drdata=0, rd_count=0, wr_count=0.
  - All in-flight pipeline entries are discarded and produce no response after release.
  - RAM contents are not cleared; simulation initialises them to zero.
- Release: the first request is accepted on the first rising edge with rst=1.
- Simultaneous reset and request: reset wins; the request is dropped and not counted.
- Out-of-range checks use the full AW-bit address. Upper bits are never truncated into range.

Test Plan:
- Reset, DW=32, RD_LAT=1: write 0xDEADBEEF to 0x10 with we=4'hF, then read 0x10 next cycle -> rvalid one cycle after each request; read returns 0xDEADBEEF; wr_count=1, rd_count=1.
- Byte lanes: over word 0x11223344 at 0x20, write 0xAABBCCDD with we=4'b0101 -> read returns 0x11BB33DD; the write response also shows 0x11BB33DD.
- RD_LAT=3, back-to-back reads of 0x0, 0x4, 0x8 preloaded with 1, 2, 3 -> rvalid high for 3 consecutive cycles starting 3 cycles after the first request; data 1, 2, 3 in order.
- Out of range, DEPTH=1024: read 0x1000, then write 0x1000 -> both responses have err=1, drdata=0; counters unchanged; the subsequent read of 0x0 is unaffected.
- Reset mid-flight, RD_LAT=4: issue 2 reads, pull rst low for 1 cycle before their responses -> no rvalid pulses ever appear; counters read 0; previously written RAM data is still readable after release.
- Saturation, CW=4: issue 20 in-range reads -> rd_count stops at 15.
